// File: rtl/stopwatch_pkg.sv
// Shared state encoding and divisor/width helpers for the stopwatch sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADJ  = 2'd2,
        ST_FULL = 2'd3
    } state_e;

    function automatic int div(input int clkHz, input int rate);
        return clkHz / rate;
    endfunction

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-sample filter and a one-cycle
// pulse on each accepted press.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = cntWidth(DB_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample that agrees with the accepted level restarts the count, so
    // only DB_CYCLES consecutive disagreeing samples flip the level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync2_q;
            pulse_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: input conditioning, timebases, STOP/RUN/ADJ/FULL FSM
// and the registered strobes that drive the digit counters and display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int DISP_HZ   = 400,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_sel,
    input  logic       sw_adj,
    input  logic       at_max,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       cnt_clr,
    output logic       scan_tick,
    output logic       blink,
    output logic       blank_sec,
    output logic       blank_min,
    output logic [1:0] state
);

    localparam int PRE_DIV  = div(CLK_HZ, 4);
    localparam int PRE_W    = cntWidth(PRE_DIV);
    localparam int SCAN_DIV = div(CLK_HZ, DISP_HZ);
    localparam int SCAN_W   = cntWidth(SCAN_DIV);

    logic pauseP, clrP;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uPauseDb (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_pause),
        .pulse_o(pauseP)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uClrDb (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_clr),
        .pulse_o(clrP)
    );

    logic              adjSync1_q, adjSync_q;
    logic              selSync1_q, selSync_q;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [1:0]        phase_q, phase_d;
    logic              blink_q, blink_d;
    logic [SCAN_W-1:0] scanCnt_q, scanCnt_d;
    logic              scanTick_q, scanTick_d;
    state_e            state_q, state_d;
    logic              secInc_q, secInc_d;
    logic              minInc_q, minInc_d;
    logic              cntClr_q, cntClr_d;

    logic tick4, tick2, tick1, runStart;

    always_ff @(posedge clk) begin
        if (reset) begin
            adjSync1_q <= 1'b0;
            adjSync_q  <= 1'b0;
            selSync1_q <= 1'b0;
            selSync_q  <= 1'b0;
            presc_q    <= '0;
            phase_q    <= 2'd0;
            blink_q    <= 1'b0;
            scanCnt_q  <= '0;
            scanTick_q <= 1'b0;
            state_q    <= ST_STOP;
            secInc_q   <= 1'b0;
            minInc_q   <= 1'b0;
            cntClr_q   <= 1'b0;
        end else begin
            adjSync1_q <= sw_adj;
            adjSync_q  <= adjSync1_q;
            selSync1_q <= sw_sel;
            selSync_q  <= selSync1_q;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            blink_q    <= blink_d;
            scanCnt_q  <= scanCnt_d;
            scanTick_q <= scanTick_d;
            state_q    <= state_d;
            secInc_q   <= secInc_d;
            minInc_q   <= minInc_d;
            cntClr_q   <= cntClr_d;
        end
    end

    assign tick4 = (presc_q == PRE_W'(PRE_DIV - 1));
    assign tick2 = tick4 & phase_q[0];
    assign tick1 = tick4 & (phase_q == 2'd3);

    // Next state and strobes; clear outranks the mode switch, overflow and pause.
    always_comb begin
        state_d  = state_q;
        cntClr_d = 1'b0;
        if (clrP) begin
            cntClr_d = 1'b1;
            state_d  = adjSync_q ? ST_ADJ : ST_STOP;
        end else if (adjSync_q) begin
            state_d = ST_ADJ;
        end else if (state_q == ST_ADJ) begin
            state_d = ST_STOP;
        end else if (state_q == ST_RUN && at_max) begin
            state_d = ST_FULL;
        end else if (pauseP) begin
            if (state_q == ST_STOP) begin
                state_d = ST_RUN;
            end else if (state_q == ST_RUN) begin
                state_d = ST_STOP;
            end
        end

        secInc_d = 1'b0;
        minInc_d = 1'b0;
        if (!cntClr_d) begin
            secInc_d = (state_q == ST_RUN && tick1 && !at_max) ||
                       (state_q == ST_ADJ && selSync_q && tick2);
            minInc_d = (state_q == ST_ADJ && !selSync_q && tick2);
        end
    end

    assign runStart = (state_q == ST_STOP) && (state_d == ST_RUN);

    // Restarting the timebase on STOP->RUN makes the first counted second full length.
    always_comb begin
        presc_d = tick4 ? '0 : presc_q + PRE_W'(1);
        phase_d = tick4 ? phase_q + 2'd1 : phase_q;
        blink_d = blink_q ^ tick4;
        if (runStart) begin
            presc_d = '0;
            phase_d = 2'd0;
        end
    end

    always_comb begin
        scanTick_d = (scanCnt_q == SCAN_W'(SCAN_DIV - 1));
        scanCnt_d  = scanTick_d ? '0 : scanCnt_q + SCAN_W'(1);
    end

    assign sec_inc   = secInc_q;
    assign min_inc   = minInc_q;
    assign cnt_clr   = cntClr_q;
    assign scan_tick = scanTick_q;
    assign blink     = blink_q;
    assign blank_sec = (state_q == ST_ADJ) & selSync_q & blink_q;
    assign blank_min = (state_q == ST_ADJ) & ~selSync_q & blink_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with a fast 16 Hz clock,
// 4 Hz scan rate and a 3-sample debounce.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_pause, btn_clr, sw_sel, sw_adj, at_max;
    logic       sec_inc, min_inc, cnt_clr, scan_tick, blink, blank_sec, blank_min;
    logic [1:0] state;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    int firstA, firstB, lastA, countA, countB, countC, countD, countE;
    logic prevBlink;

    stopwatch_ctrl #(.CLK_HZ(16), .DISP_HZ(4), .DB_CYCLES(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_pause(btn_pause),
        .btn_clr  (btn_clr),
        .sw_sel   (sw_sel),
        .sw_adj   (sw_adj),
        .at_max   (at_max),
        .sec_inc  (sec_inc),
        .min_inc  (min_inc),
        .cnt_clr  (cnt_clr),
        .scan_tick(scan_tick),
        .blink    (blink),
        .blank_sec(blank_sec),
        .blank_min(blank_min),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic applyStimulus(input logic pause, input logic clr, input logic adj,
                                 input logic sel, input logic max);
        btn_pause = pause;
        btn_clr   = clr;
        sw_adj    = adj;
        sw_sel    = sel;
        at_max    = max;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and idle: timebases free-run, FSM stays in STOP.
        applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("rst_sec_inc", sec_inc, 0);
        checkOutput("rst_min_inc", min_inc, 0);
        checkOutput("rst_cnt_clr", cnt_clr, 0);
        checkOutput("rst_scan", scan_tick, 0);
        checkOutput("rst_blink", blink, 0);
        checkOutput("rst_blank_sec", blank_sec, 0);
        checkOutput("rst_blank_min", blank_min, 0);
        checkOutput("rst_state", state, 0);
        reset = 1'b0;

        firstA = -1; firstB = -1; lastA = -1; countA = 0; countB = 0; countC = 0;
        prevBlink = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            nextCycle();
            if (scan_tick) begin
                countA++;
                lastA = i;
                if (firstA < 0) firstA = i;
            end
            if (blink !== prevBlink) begin
                countB++;
                if (firstB < 0) firstB = i;
            end
            prevBlink = blink;
            if (state != 2'd0) countC++;
            countC += int'(sec_inc) + int'(min_inc) + int'(cnt_clr) + int'(blank_sec) + int'(blank_min);
        end
        checkOutput("idle_scan_count", countA, 16);
        checkOutput("idle_scan_first", firstA, 4);
        checkOutput("idle_scan_last", lastA, 64);
        checkOutput("idle_blink_toggles", countB, 16);
        checkOutput("idle_blink_first", firstB, 4);
        checkOutput("idle_quiet", countC, 0);

        // Pause press: RUN after sync + debounce, then one sec_inc per 16 cycles.
        btn_pause = 1'b1;
        firstA = -1; firstB = -1; lastA = -1; countA = 0;
        for (int i = 1; i <= 80; i++) begin
            nextCycle();
            if (state == 2'd1 && firstA < 0) firstA = i;
            if (sec_inc) begin
                countA++;
                lastA = i;
                if (firstB < 0) firstB = i;
            end
            if (i == 10) btn_pause = 1'b0;
        end
        checkOutput("run_entry_cycle", firstA, 6);
        checkOutput("run_first_sec", firstB - firstA, 16);
        checkOutput("run_sec_count", countA, 4);
        checkOutput("run_sec_last", lastA, 70);
        checkOutput("run_state_held", state, 1);

        // Bounce shorter than the debounce window must not toggle the FSM.
        countA = 0;
        for (int i = 0; i < 24; i++) begin
            btn_pause = (i == 0 || i == 2);
            nextCycle();
            if (state != 2'd1) countA++;
        end
        checkOutput("bounce_no_toggle", countA, 0);

        // at_max raised just before tick1: increment suppressed, FSM goes FULL.
        firstA = -1;
        for (int i = 1; i <= 20; i++) begin
            nextCycle();
            if (sec_inc) begin
                firstA = i;
                break;
            end
        end
        checkOutput("full_sync_sec_seen", firstA > 0, 1);
        for (int i = 0; i < 15; i++) nextCycle();
        at_max = 1'b1;
        nextCycle();
        checkOutput("full_no_sec_inc", sec_inc, 0);
        checkOutput("full_state", state, 3);

        countA = 0; countB = 0;
        btn_pause = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            nextCycle();
            if (i == 6) btn_pause = 1'b0;
            if (state != 2'd3) countA++;
            countB += int'(sec_inc);
        end
        checkOutput("full_pause_ignored", countA, 0);
        checkOutput("full_no_strobes", countB, 0);

        btn_clr = 1'b1;
        firstA = -1; countA = 0;
        for (int i = 1; i <= 12; i++) begin
            nextCycle();
            if (cnt_clr) begin
                countA++;
                if (firstA < 0) firstA = i;
            end
            if (i == 6) btn_clr = 1'b0;
        end
        checkOutput("full_clr_cycle", firstA, 6);
        checkOutput("full_clr_count", countA, 1);
        checkOutput("full_clr_state", state, 0);
        at_max = 1'b0;

        // Adjust seconds: state ADJ, sec_inc every 8 cycles, blank_sec follows blink.
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        firstA = -1;
        for (int i = 1; i <= 6; i++) begin
            nextCycle();
            if (state == 2'd2 && firstA < 0) firstA = i;
        end
        checkOutput("adj_entry_cycle", firstA, 3);
        firstA = -1; firstB = -1; countA = 0; countB = 0; countC = 0; countD = 0; countE = 0;
        prevBlink = blink;
        for (int i = 1; i <= 40; i++) begin
            nextCycle();
            if (sec_inc) begin
                countA++;
                if (firstA < 0) firstA = i;
                else if (firstB < 0) firstB = i;
            end
            countB += int'(min_inc);
            if (blank_sec !== blink) countC++;
            countD += int'(blank_min);
            if (blink !== prevBlink) countE++;
            prevBlink = blink;
        end
        checkOutput("adj_sec_count", countA, 5);
        checkOutput("adj_sec_period", firstB - firstA, 8);
        checkOutput("adj_sec_no_min", countB, 0);
        checkOutput("adj_blank_sec_track", countC, 0);
        checkOutput("adj_blank_min_off", countD, 0);
        checkOutput("adj_blink_toggles", countE, 10);

        // Adjust minutes.
        sw_sel = 1'b0;
        for (int i = 0; i < 4; i++) nextCycle();
        countA = 0; countB = 0; countC = 0; countD = 0;
        for (int i = 1; i <= 40; i++) begin
            nextCycle();
            countA += int'(min_inc);
            countB += int'(sec_inc);
            if (blank_min !== blink) countC++;
            countD += int'(blank_sec);
        end
        checkOutput("adjm_min_count", countA, 5);
        checkOutput("adjm_no_sec", countB, 0);
        checkOutput("adjm_blank_min_track", countC, 0);
        checkOutput("adjm_blank_sec_off", countD, 0);

        sw_adj = 1'b0;
        firstA = -1;
        for (int i = 1; i <= 6; i++) begin
            nextCycle();
            if (state == 2'd0 && firstA < 0) firstA = i;
        end
        checkOutput("adj_exit_cycle", firstA, 3);

        // Clear and at_max coincide with tick1 in RUN: clear wins everything.
        btn_pause = 1'b1;
        firstA = -1;
        for (int i = 1; i <= 6; i++) begin
            nextCycle();
            if (state == 2'd1 && firstA < 0) firstA = i;
        end
        btn_pause = 1'b0;
        checkOutput("run2_entry_cycle", firstA, 6);
        for (int i = 0; i < 10; i++) nextCycle();
        btn_clr = 1'b1;
        for (int i = 0; i < 5; i++) nextCycle();
        at_max = 1'b1;
        nextCycle();
        checkOutput("clrmax_cnt_clr", cnt_clr, 1);
        checkOutput("clrmax_sec_inc", sec_inc, 0);
        checkOutput("clrmax_state", state, 0);
        btn_clr = 1'b0;
        at_max = 1'b0;
        countA = 0;
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            if (state != 2'd0) countA++;
        end
        checkOutput("clrmax_stays_stop", countA, 0);

        // Reset in the middle of a debounce window discards the press.
        btn_pause = 1'b1;
        for (int i = 0; i < 3; i++) nextCycle();
        reset = 1'b1;
        btn_pause = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("rstdb_state_in_reset", state, 0);
        reset = 1'b0;
        countA = 0;
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            if (state != 2'd0) countA++;
        end
        checkOutput("rstdb_press_lost", countA, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
